// File: rtl/dm_write_buffer.sv
// Write-back FIFO between datapath and 8-bit data memory: rounds/shifts each result to a pixel
// and retires queued writes over a mem_we/mem_ack handshake. Option: DM_WRITE_SATURATE_EN.
module dm_write_buffer #(
  parameter int unsigned DATA_W = 19,
  parameter int unsigned MEM_W  = 8,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SHIFT  = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_wr_addr,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [MEM_W-1:0]  o_mem_wdata,
  input  logic              i_mem_ack,
  output logic              o_busy,
  input  logic              i_clr_ovf,
  output logic              o_ovf_flag
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [DATA_W:0]  ONE      = {{DATA_W{1'b0}}, 1'b1};
  localparam logic [DATA_W:0]  ROUND    = (SHIFT > 0) ? (ONE << RND_POS) : '0;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e             r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_wptr, r_rptr;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic               r_ovf;
  logic [MEM_W-1:0]   r_fifo_data [DEPTH];
  logic [ADDR_W-1:0]  r_fifo_addr [DEPTH];

  logic               w_push, w_pop;
  logic [DATA_W:0]    w_sum, w_shr;
  logic               w_ovf;
  logic [MEM_W-1:0]   w_conv;

  // One extra bit keeps the rounding add from wrapping near full scale.
  assign w_sum = {1'b0, i_wr_data} + ROUND;
  assign w_shr = w_sum >> SHIFT;
  assign w_ovf = |w_shr[DATA_W:MEM_W];

`ifdef DM_WRITE_SATURATE_EN
  assign w_conv = w_ovf ? {MEM_W{1'b1}} : w_shr[MEM_W-1:0];
`else
  assign w_conv = w_shr[MEM_W-1:0];
`endif

  assign o_wr_ready  = (r_count < FULL_CNT);
  assign o_mem_we    = (r_state == StIssue);
  assign w_push      = i_wr_valid && o_wr_ready;
  assign w_pop       = o_mem_we && i_mem_ack;
  assign o_busy      = (r_count != '0) || o_mem_we;
  assign o_ovf_flag  = r_ovf;
  // Head is only meaningful while issuing; drive zero otherwise.
  assign o_mem_addr  = o_mem_we ? r_fifo_addr[r_rptr] : '0;
  assign o_mem_wdata = o_mem_we ? r_fifo_data[r_rptr] : '0;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if ((r_count != '0) || w_push) w_state_nxt = StIssue;
      StIssue: if (i_mem_ack && (w_count_nxt == '0)) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state <= StIdle;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && w_ovf) begin
        r_ovf <= 1'b1;
      end else if (i_clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RST && w_push) begin
      r_fifo_data[r_wptr] <= w_conv;
      r_fifo_addr[r_wptr] <= i_wr_addr;
    end
  end

endmodule

// File: doc/dm_write_buffer.md
# dm_write_buffer

Write-back buffer between the datapath and the 8-bit data memory: the counterpart of the memory-read data register. Accepts 19-bit datapath results (e.g. 4×4 pixel-window sums) with a target address, and scales each one to an 8-bit pixel by rounded right-shift plus saturation. Queues up to DEPTH pending writes and drives the data memory write port with a mem_we/mem_ack handshake, so the core does not stall on memory latency.

## Interface
- DATA_W, 19, datapath word width
- MEM_W, 8, memory word width
- ADDR_W, 16, memory address width
- DEPTH, 4, FIFO entries (power of two, ≥2)
- SHIFT, 4, right-shift applied to input (0..DATA_W-MEM_W)
- clk  in  1  clock
- RST  in  1  reset, synchronous, active-high
- wr_valid  in  1  datapath write request
- wr_ready  out  1  buffer can accept; equals (count < DEPTH)
- wr_data  in  DATA_W  unsigned value to store
- wr_addr  in  ADDR_W  target address
- mem_we  out  1  memory write strobe, held until acknowledged
- mem_addr  out  ADDR_W  write address (FIFO head)
- mem_wdata  out  MEM_W  write data (FIFO head)
- mem_ack  in  1  memory accepted current write this cycle
- busy  out  1  count != 0 or mem_we high
- clr_ovf  in  1  clears ovf_flag
- ovf_flag  out  1  sticky: a converted value exceeded 2^MEM_W-1

## Operation
- Push: on an edge where wr_valid && wr_ready, the converted data and wr_addr are written to FIFO tail. There is no bypass: a push while full is refused even if a pop happens in the same cycle.
- Conversion (combinational at push, result stored in the FIFO): t = wr_data + (SHIFT>0 ? 2^(SHIFT-1) : 0), computed at DATA_W+1 bits (no wrap). r = t >> SHIFT. If r > 2^MEM_W-1, the overflow condition is true.
- FSM states:
  - IDLE: mem_we=0. Go to ISSUE on the next edge if count != 0 or a push occurs.
  - ISSUE: mem_we=1, mem_addr/mem_wdata = FIFO head.
    - mem_ack=1 pops the head. Stay in ISSUE if entries remain after the pop (counting a same-cycle push); otherwise go to IDLE.
    - mem_ack=0: hold; head and outputs stay stable.
- mem_ack is ignored in IDLE.
- Pointers wrap modulo DEPTH. Simultaneous push and pop leaves count unchanged.
- ovf_flag sets on an edge pushing an overflowing value. clr_ovf clears it. If set and clear coincide, set wins.
- Reset values: count=0, pointers=0, state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, ovf_flag=0, busy=0, wr_ready=1.
- RST mid-operation flushes the FIFO; an unacknowledged write is abandoned. RST has priority over push and ack.

## Timing
- Accept edge E into an empty buffer: mem_we is high in the cycle after E (1-cycle latency).
- Sustained mem_ack=1 retires one entry per cycle, with no bubble between entries.
- wr_ready rises the cycle after the pop edge that leaves count < DEPTH.
- mem_addr and mem_wdata are stable whenever mem_we=1 until the acking edge.

## Configuration
- DM_WRITE_SATURATE_EN defined: an overflowing r is stored as 2^MEM_W-1 (0xFF).
- Not defined: r[MEM_W-1:0] is stored (truncation).
- ovf_flag behaves identically in both builds.

## Test plan
- Single write: wr_data=0x000F0, wr_addr=0x0010, mem_ack high on first mem_we cycle -> mem_we high 1 cycle after accept, mem_wdata=0x0F, mem_addr=0x0010, then IDLE, busy=0, ovf_flag=0.
- Rounding/overflow: wr_data=0x00FF8 -> mem_wdata=0xFF and ovf_flag=1 (saturate build), 0x00 and ovf_flag=1 (truncate build). wr_data=0x7FFFF -> 0xFF (saturate build), no width wrap. clr_ovf pulse -> ovf_flag=0.
- Full: 5 back-to-back requests with mem_ack=0 -> 4 accepted, wr_ready=0 after the 4th, mem_wdata frozen at entry 0. One ack -> wr_ready=1 next cycle, 5th accepted.
- Streaming: 3 entries queued, mem_ack held high -> 3 writes on 3 consecutive cycles in FIFO order, then mem_we=0.
- Simultaneous push+pop at count=2 -> count stays 2, order preserved.
- RST asserted during ISSUE with mem_ack=0 and 3 entries queued -> next cycle mem_we=0, busy=0, wr_ready=1. A later single push writes only the new value.
